// File: rtl/tamarisc_pkg.sv
// ---------------------------------------------------------------------------
// tamarisc_pkg
//   Shared types and constants for the instruction fetch stage.
//   - NOP_INSTR      : canonical RISC-V NOP (addi x0,x0,0), shown to decode when
//                      nothing valid is at the head of the fetch buffer.
//   - fetch_state_e  : fetch FSM state encoding.
//   - fetch_entry_t  : one buffered fetch result (PC, instruction word, flags).
//   - word_addr()    : word-aligned form of a PC.
//   - pc_misaligned(): PC is not on a 4-byte boundary.
// ---------------------------------------------------------------------------
package tamarisc_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'd0,
    FS_REQ      = 3'd1,
    FS_WAIT_RSP = 3'd2,
    FS_DISCARD  = 3'd3,
    FS_HALT     = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic        misalign;
  } fetch_entry_t;

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Instruction memory read bus (req/gnt/rvalid).
//   req    : read request            (master -> slave)
//   addr   : word address            (master -> slave)
//   gnt    : request accepted        (slave -> master)
//   rvalid : read data valid         (slave -> master), one per grant, in order
//   rdata  : read data               (slave -> master)
//   err    : bus error, qualified by rvalid (slave -> master)
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );
endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO of fetch_entry_t. Pointers wrap modulo DEPTH (power of two).
//   clear has priority over push/pop; push+pop on a full FIFO keeps the count.
//   Ports:
//     clk_i, rst_n_i : clock, asynchronous active-low reset
//     push / wdata   : write an entry
//     pop            : drop the head entry
//     clear          : discard all entries
//     full, empty    : occupancy flags
//     count          : number of stored entries ($clog2(DEPTH)+1 bits)
//     head           : oldest entry (valid when !empty)
// ---------------------------------------------------------------------------
module fetch_fifo
  import tamarisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  input  logic                       clear,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  // Pointer and occupancy bookkeeping; clear empties the buffer immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; a push on full+pop overwrites the slot being read out this cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !clear) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  fetch_fifo_chk u_chk (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// ---------------------------------------------------------------------------
// fetch_fifo_chk
//   Simulation-only protocol checks for fetch_fifo.
//   Ports: clk_i, rst_n_i, push, pop, clear, full, empty (all observed only).
// ---------------------------------------------------------------------------
module fetch_fifo_chk (
  input logic clk_i,
  input logic rst_n_i,
  input logic push,
  input logic pop,
  input logic clear,
  input logic full,
  input logic empty
);

  // A push into a full buffer is only legal when the head leaves the same cycle.
  property p_no_overflow;
    @(posedge clk_i) disable iff (!rst_n_i)
      !(push && full && !pop && !clear);
  endproperty

  // The head may only be consumed while something is stored.
  property p_no_underflow;
    @(posedge clk_i) disable iff (!rst_n_i)
      !(pop && empty && !clear);
  endproperty

  a_no_overflow:  assert property (p_no_overflow)
    else $error("fetch_fifo: push while full without pop");
  a_no_underflow: assert property (p_no_underflow)
    else $error("fetch_fifo: pop while empty");

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage between the PC stage and decode. Issues word reads
//   at pc_i (at most one outstanding), pulses incr_pc_o on each accepted grant,
//   buffers returned words with their PC and presents the oldest to decode.
//   A redirect (flush_i) empties the buffer and drops any in-flight response.
//   Ports:
//     clk_i, rst_n_i    : clock, asynchronous active-low reset
//     pc_i              : current fetch PC
//     flush_i           : redirect; PC stage loads its new value this cycle
//     stall_i           : decode cannot accept; head entry is held
//     incr_pc_o         : 1-cycle pulse, PC stage advances by 4
//     imem              : instruction memory bus (master side)
//     instr_valid_o     : head entry valid
//     instr_o           : head instruction (NOP when empty)
//     instr_pc_o        : PC of head instruction (0 when empty)
//     fetch_fault_o     : head entry returned a bus error
//     fetch_misalign_o  : head entry is a misaligned fetch
// ---------------------------------------------------------------------------
module fetch_unit
  import tamarisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [31:0]        pc_i,
  input  logic               flush_i,
  input  logic               stall_i,
  output logic               incr_pc_o,
  fetch_unit_if.master       imem,
  output logic               instr_valid_o,
  output logic [31:0]        instr_o,
  output logic [31:0]        instr_pc_o,
  output logic               fetch_fault_o,
  output logic               fetch_misalign_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [2:0] S_IDLE     = FS_IDLE;
  localparam logic [2:0] S_REQ      = FS_REQ;
  localparam logic [2:0] S_WAIT_RSP = FS_WAIT_RSP;
  localparam logic [2:0] S_DISCARD  = FS_DISCARD;
  localparam logic [2:0] S_HALT     = FS_HALT;

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [31:0]   pc_latch_r;
  logic          latch_pc_s;
  logic          req_s;
  logic          incr_s;
  logic          push_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  rsp_entry_s;
  fetch_entry_t  mis_entry_s;
  logic          pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW-1:0] occ_s;
  fetch_entry_t  head_s;
  logic          misaligned_s;
  logic          room_now_s;
  logic          room_after_push_s;

  assign misaligned_s = pc_misaligned(pc_i);
  assign pop_s        = !fifo_empty_s && !stall_i;

  // Occupancy once this cycle's pop has left. There is never more than one
  // response outstanding and the FSM only waits for it after reserving a slot,
  // so "room" below already accounts for the in-flight word.
  assign occ_s             = fifo_count_s - CW'(pop_s);
  assign room_now_s        = !fifo_full_s || pop_s;
  assign room_after_push_s = (occ_s < CW'(DEPTH - 1));

  assign rsp_entry_s = '{pc: pc_latch_r, instr: imem.rdata, fault: imem.err, misalign: 1'b0};
  assign mis_entry_s = '{pc: pc_i, instr: NOP_INSTR, fault: 1'b0, misalign: 1'b1};

  // Fetch FSM: next state, bus request, PC advance and buffer push.
  always_comb begin
    state_nxt_s  = state_r;
    req_s        = 1'b0;
    incr_s       = 1'b0;
    latch_pc_s   = 1'b0;
    push_s       = 1'b0;
    push_entry_s = rsp_entry_s;
    case (state_r)
      S_IDLE: begin
        if (flush_i) begin
          state_nxt_s = S_IDLE;
        end else if (room_now_s) begin
          if (misaligned_s) begin
            push_s       = 1'b1;
            push_entry_s = mis_entry_s;
            state_nxt_s  = S_HALT;
          end else begin
            state_nxt_s = S_REQ;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        // Request is not held against flush: an ungranted request may be
        // retracted, but a grant arriving with the flush still owes a response.
        req_s = !misaligned_s;
        if (req_s && imem.gnt) begin
          latch_pc_s = 1'b1;
          if (flush_i) begin
            state_nxt_s = S_DISCARD;
          end else begin
            incr_s      = 1'b1;
            state_nxt_s = S_WAIT_RSP;
          end
        end else if (flush_i) begin
          state_nxt_s = S_IDLE;
        end else if (misaligned_s) begin
          push_s       = 1'b1;
          push_entry_s = mis_entry_s;
          state_nxt_s  = S_HALT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT_RSP: begin
        if (imem.rvalid) begin
          if (flush_i) begin
            state_nxt_s = S_IDLE;
          end else begin
            push_s = 1'b1;
            if (imem.err) begin
              state_nxt_s = S_HALT;
            end else if (!room_after_push_s) begin
              state_nxt_s = S_IDLE;
            end else if (misaligned_s) begin
              state_nxt_s = S_REQ;
            end else begin
              // Back-to-back: the next request goes out in the response cycle.
              req_s = 1'b1;
              if (imem.gnt) begin
                latch_pc_s  = 1'b1;
                incr_s      = 1'b1;
                state_nxt_s = S_WAIT_RSP;
              end else begin
                state_nxt_s = S_REQ;
              end
            end
          end
        end else if (flush_i) begin
          state_nxt_s = S_DISCARD;
        end else begin
          state_nxt_s = S_WAIT_RSP;
        end
      end
      S_DISCARD: begin
        if (imem.rvalid) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DISCARD;
        end
      end
      S_HALT: begin
        if (flush_i) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_HALT;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC of the outstanding request, captured on grant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_latch_r <= '0;
    end else if (latch_pc_s) begin
      pc_latch_r <= pc_i;
    end else begin
      pc_latch_r <= pc_latch_r;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push_s),
    .wdata   (push_entry_s),
    .pop     (pop_s),
    .clear   (flush_i),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s),
    .head    (head_s)
  );

  assign incr_pc_o   = incr_s;
  assign imem.req    = req_s;
  assign imem.addr   = req_s ? word_addr(pc_i) : 32'h0000_0000;

  assign instr_valid_o    = !fifo_empty_s;
  assign instr_o          = fifo_empty_s ? NOP_INSTR : head_s.instr;
  assign instr_pc_o       = fifo_empty_s ? 32'h0000_0000 : head_s.pc;
  assign fetch_fault_o    = !fifo_empty_s && head_s.fault;
  assign fetch_misalign_o = !fifo_empty_s && head_s.misalign;

endmodule
